// File: rtl/rf_mp_if.sv
// Register-file access bundle: two read ports, two write ports and clear control.
// The register file connects as slave; the requester (decode/writeback) connects as master.
interface rf_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic [AW-1:0]   reg_s1;
  logic [AW-1:0]   reg_s2;
  logic [XLEN-1:0] reg_d1;
  logic [XLEN-1:0] reg_d2;
  logic [AW-1:0]   rd_a;
  logic            write_e_a;
  logic [XLEN-1:0] write_d_a;
  logic [AW-1:0]   rd_b;
  logic            write_e_b;
  logic [XLEN-1:0] write_d_b;
  logic            clr_req;
  logic            clr_busy;
  logic            clr_done;

  modport master (
    output reg_s1, reg_s2, rd_a, write_e_a, write_d_a,
           rd_b, write_e_b, write_d_b, clr_req,
    input  reg_d1, reg_d2, clr_busy, clr_done
  );

  modport slave (
    input  reg_s1, reg_s2, rd_a, write_e_a, write_d_a,
           rd_b, write_e_b, write_d_b, clr_req,
    output reg_d1, reg_d2, clr_busy, clr_done
  );
endinterface

// File: rtl/rf_mp.sv
// Multi-port register file, x0 hardwired to zero, port B wins write collisions.
// Reads are combinational (optional same-cycle bypass); a clear sweep zeroes one register per cycle.
module rf_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter bit BYPASS = 1'b1
) (
  input logic    clk,
  input logic    rst,
  rf_mp_if.slave bus
);
  localparam int            AW        = $clog2(NREGS);
  localparam logic [AW:0]   NREGS_W   = (AW+1)'(NREGS);
  localparam logic [AW-1:0] FIRST_IDX = AW'(1);
  localparam logic [AW-1:0] LAST_IDX  = AW'(NREGS - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            clr_done_c;
  logic [XLEN-1:0] regs [NREGS];
  logic            wr_a_ok;
  logic            wr_b_ok;

  // Address 0 and out-of-range addresses are never written or read back.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && ({1'b0, a} < NREGS_W);
  endfunction

  function automatic logic [XLEN-1:0] read_mux(
    input logic [AW-1:0]   a,
    input logic [XLEN-1:0] stored,
    input logic            a_wr,
    input logic [AW-1:0]   a_addr,
    input logic [XLEN-1:0] a_data,
    input logic            b_wr,
    input logic [AW-1:0]   b_addr,
    input logic [XLEN-1:0] b_data
  );
    logic [XLEN-1:0] r;
    r = '0;
    if (addr_ok(a)) begin
      r = stored;
      if (BYPASS) begin
        if (b_wr && (b_addr == a))
          r = b_data;
        else if (a_wr && (a_addr == a))
          r = a_data;
      end
    end
    return r;
  endfunction

  // Writes are only accepted while idle, which also suppresses bypass during a sweep.
  assign wr_a_ok = bus.write_e_a && addr_ok(bus.rd_a) && (state_q == IDLE);
  assign wr_b_ok = bus.write_e_b && addr_ok(bus.rd_b) && (state_q == IDLE);

  assign bus.reg_d1 = read_mux(bus.reg_s1, regs[bus.reg_s1],
                               wr_a_ok, bus.rd_a, bus.write_d_a,
                               wr_b_ok, bus.rd_b, bus.write_d_b);
  assign bus.reg_d2 = read_mux(bus.reg_s2, regs[bus.reg_s2],
                               wr_a_ok, bus.rd_a, bus.write_d_a,
                               wr_b_ok, bus.rd_b, bus.write_d_b);

  assign bus.clr_busy = (state_q == SWEEP);
  assign bus.clr_done = clr_done_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= FIRST_IDX;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    clr_done_c = 1'b0;
    case (state_q)
      IDLE: begin
        idx_d = FIRST_IDX;
        if (bus.clr_req)
          state_d = SWEEP;
      end
      SWEEP: begin
        if (idx_q == LAST_IDX) begin
          clr_done_c = 1'b1;
          state_d    = IDLE;
          idx_d      = FIRST_IDX;
        end else begin
          idx_d = idx_q + FIRST_IDX;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = FIRST_IDX;
      end
    endcase
  end

  // Port B is written last so it wins a same-address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (state_q == SWEEP) begin
      regs[idx_q] <= '0;
    end else begin
      if (wr_a_ok)
        regs[bus.rd_a] <= bus.write_d_a;
      if (wr_b_ok)
        regs[bus.rd_b] <= bus.write_d_b;
    end
  end
endmodule

// File: doc/rf_mp.md
Name: rf_mp

Overview:
- Parametrised successor to the core register file: XLEN-wide, NREGS-deep, two combinational read ports, two write ports with a fixed priority.
- Adds optional write-to-read bypass and a sequential clear engine that sweeps the array one register per cycle.
- Sits in the decode/writeback path of the core. The second write port serves a late-writeback unit (load/mul).

Parameters:
- XLEN, 32, data width of every register.
- NREGS, 32, number of registers (2..64, need not be a power of 2).
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports; 0 = reads show only committed state.
- Derived (localparam): AW = $clog2(NREGS), address width.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- reg_s1  in  AW  read address, port 1.
- reg_s2  in  AW  read address, port 2.
- reg_d1  out  XLEN  read data, port 1 (combinational).
- reg_d2  out  XLEN  read data, port 2 (combinational).
- rd_a  in  AW  write address, port A.
- write_e_a  in  1  write enable, port A.
- write_d_a  in  XLEN  write data, port A.
- rd_b  in  AW  write address, port B.
- write_e_b  in  1  write enable, port B.
- write_d_b  in  XLEN  write data, port B.
- clr_req  in  1  single-cycle clear request.
- clr_busy  out  1  high while a clear sweep is in progress.
- clr_done  out  1  one-cycle pulse on the final sweep cycle.

Behaviour:
- Reset: rst asynchronously sets all registers to 0, FSM to IDLE, sweep index to 1, clr_busy=0, clr_done=0. Reset takes effect immediately, including mid-sweep.
- Register 0 is hardwired zero. Writes to address 0 are dropped. Reads of address 0 return 0 regardless of bypass.
- Addresses >= NREGS: writes are dropped, reads return 0.
- Write: on the rising clk edge, if write_e_x=1 and the address is valid and nonzero, the register takes write_d_x. The new value is visible one edge after issue.
- Same-address collision: when both ports write the same address in one cycle, port B wins and port A's data is lost. Writes to different addresses both commit.
- Read: reg_dN = array[reg_sN], purely combinational, zero cycles of latency.
- Bypass (BYPASS=1): a read address that matches an enabled, valid, nonzero write address in the same cycle returns that write's data before the edge. If both ports match, port B's data is returned.
- Bypass (BYPASS=0): the read returns the pre-edge register value.
- Bypass is suppressed while clr_busy=1.
- Clear FSM, states IDLE and SWEEP:
  - IDLE -> SWEEP on a rising edge with clr_req=1. clr_busy goes to 1 from the next cycle; the index starts at 1.
  - Each SWEEP cycle: array[index] <= 0, then index increments.
  - When index = NREGS-1, clr_done=1 for that cycle and the FSM returns to IDLE on the edge. clr_busy falls in the following cycle.
  - clr_busy therefore stays high for exactly NREGS-1 cycles.
- During SWEEP:
  - Both write ports are ignored (dropped, not queued).
  - Reads return current array contents. Not-yet-cleared registers show stale data.
  - clr_req is ignored.
- clr_req together with writes in the IDLE cycle: the writes commit on that edge, then the sweep clears them.
- After clr_done, the index returns to 1, so a back-to-back clr_req restarts cleanly.

Test Plan:
- Basic: write 42 to x4 via port A. Next cycle read reg_s1=4, reg_s2=0 -> reg_d1=42, reg_d2=0. Write 99 to x2 via port B -> reads x2=99, x4=42.
- x0 and range: write 0xDEAD to x0 and, with NREGS=20, to address 25 -> reads of 0 and 25 return 0. Other registers are unchanged.
- Collision: same cycle, A writes 7 to x5 and B writes 9 to x5 -> x5=9. A writes 3 to x6 and B writes 4 to x7 -> x6=3, x7=4.
- Bypass: BYPASS=1, reg_s1=8 while B writes 0x55 to x8 -> reg_d1=0x55 before the edge. BYPASS=0, same stimulus -> reg_d1 shows the old value, and 0x55 appears after the edge.
- Clear sweep: fill x1..x31 with their index, pulse clr_req -> clr_busy high for 31 cycles and clr_done pulses once. A write of 77 to x3 mid-sweep is dropped. Afterwards all reads are 0.
- Async reset: assert rst mid-sweep, between clock edges -> clr_busy=0 and all registers 0 immediately. A fresh clr_req afterwards completes in 31 cycles.
